cpu_run_ctrl: RTL and testbench

Run/halt sequencer for the RISC-V core on the comprocboard. It replaces gating of the core clock with a synchronous clock-enable, and generates the core reset from a debounced push-button. It also stops the core on exit and latches the exit status, program counter and retired-cycle count. An optional single-step mode advances the core one enabled cycle per button press.

---
 rtl/cpu_run_ctrl.sv | 151 +++++++++++++++
 tb/tb_cpu_run_ctrl.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_run_ctrl.sv
// Run/halt sequencer for the core: drives a synchronous clock enable instead of a gated clock,
// builds the core reset from a debounced push-button, supports single-stepping and latches the
// exit status, PC and enabled-cycle count when the core signals exit.
module cpu_run_ctrl #(
    parameter int unsigned RESET_CYCLES    = 16,
    parameter int unsigned DEBOUNCE_CYCLES = 270000
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        button_rst_n,
    input  logic        button_step_n,
    input  logic        step_mode,
    input  logic        core_exit,
    input  logic        core_success,
    input  logic [31:0] core_pc,
    output logic        core_reset,
    output logic        core_clock_en,
    output logic        halted,
    output logic        exit_success,
    output logic [31:0] exit_pc,
    output logic [31:0] cycle_count
);

    localparam int unsigned    DbW      = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DbW-1:0] DbLast   = DbW'(DEBOUNCE_CYCLES - 1);
    localparam logic [15:0]    HoldInit = 16'(RESET_CYCLES - 1);

    typedef enum logic [2:0] {
        StResetHold,
        StRun,
        StStepIdle,
        StStepPulse,
        StHalt
    } state_e;

    // Bit 0 is the reset button, bit 1 the step button.
    logic [1:0]     btn_raw;
    logic [1:0]     sync1_q, sync2_q, sample_q, level_q;
    logic [DbW-1:0] db_cnt_q [2];
    logic           step_level_prev_q;
    logic           step_evt;
    logic           btn_reset;

    state_e         state_q, state_d;
    logic [15:0]    hold_q, hold_d;
    logic           core_reset_q, clock_en_q, halted_q, exit_success_q;
    logic [31:0]    exit_pc_q, cycle_count_q;
    logic           capture;

    assign btn_raw   = {button_step_n, button_rst_n};
    assign step_evt  = step_level_prev_q & ~level_q[1];
    assign btn_reset = ~level_q[0];
    assign capture   = ((state_q == StRun) || (state_q == StStepPulse)) && clock_en_q && core_exit;

    // Two-flop synchronizers followed by debouncers; any change of the synchronized level
    // restarts the stability counter, and the level is accepted once the counter has run out.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            sync1_q           <= 2'b11;
            sync2_q           <= 2'b11;
            sample_q          <= 2'b11;
            level_q           <= 2'b11;
            step_level_prev_q <= 1'b1;
            for (int i = 0; i < 2; i++) begin
                db_cnt_q[i] <= '0;
            end
        end else begin
            sync1_q           <= btn_raw;
            sync2_q           <= sync1_q;
            sample_q          <= sync2_q;
            step_level_prev_q <= level_q[1];
            for (int i = 0; i < 2; i++) begin
                if (sync2_q[i] != sample_q[i]) begin
                    db_cnt_q[i] <= '0;
                end else if (db_cnt_q[i] != DbLast) begin
                    db_cnt_q[i] <= db_cnt_q[i] + DbW'(1);
                end else begin
                    level_q[i] <= sync2_q[i];
                end
            end
        end
    end

    // Sequencer next state; a step press wins over a step_mode change in STEP_IDLE.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        unique case (state_q)
            StResetHold: begin
                if (hold_q == '0) begin
                    state_d = step_mode ? StStepIdle : StRun;
                end else begin
                    hold_d = hold_q - 16'd1;
                end
            end
            StRun: begin
                if (core_exit) begin
                    state_d = StHalt;
                end else if (step_mode) begin
                    state_d = StStepIdle;
                end
            end
            StStepIdle: begin
                if (step_evt) begin
                    state_d = StStepPulse;
                end else if (!step_mode) begin
                    state_d = StRun;
                end
            end
            StStepPulse: state_d = core_exit ? StHalt : StStepIdle;
            StHalt:      state_d = StHalt;
            default:     state_d = StResetHold;
        endcase
    end

    // State, registered outputs and exit capture; either reset source restarts the hold.
    always_ff @(posedge clock) begin
        if (!reset_n || btn_reset) begin
            state_q        <= StResetHold;
            hold_q         <= HoldInit;
            core_reset_q   <= 1'b1;
            clock_en_q     <= 1'b0;
            halted_q       <= 1'b0;
            exit_success_q <= 1'b0;
            exit_pc_q      <= '0;
            cycle_count_q  <= '0;
        end else begin
            state_q      <= state_d;
            hold_q       <= hold_d;
            core_reset_q <= (state_d == StResetHold);
            clock_en_q   <= (state_d == StResetHold) || (state_d == StRun) ||
                            (state_d == StStepPulse);
            halted_q     <= (state_d == StHalt);
            if (capture) begin
                exit_success_q <= core_success;
                exit_pc_q      <= core_pc;
            end
            if (clock_en_q && !core_reset_q && (cycle_count_q != 32'hFFFF_FFFF)) begin
                cycle_count_q <= cycle_count_q + 32'd1;
            end
        end
    end

    assign core_reset    = core_reset_q;
    assign core_clock_en = clock_en_q;
    assign halted        = halted_q;
    assign exit_success  = exit_success_q;
    assign exit_pc       = exit_pc_q;
    assign cycle_count   = cycle_count_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Bench for cpu_run_ctrl: a cycle-level behavioural model is compared against the DUT after
// every clock edge, with directed scenarios pinned by hand-computed values and a random phase.
module tb_cpu_run_ctrl;

    localparam int RC  = 16;
    localparam int DEB = 4;

    localparam int M_HOLD  = 0;
    localparam int M_RUN   = 1;
    localparam int M_IDLE  = 2;
    localparam int M_PULSE = 3;
    localparam int M_HALT  = 4;

    logic        clock = 1'b0;
    logic        reset_n, button_rst_n, button_step_n, step_mode;
    logic        core_exit, core_success;
    logic [31:0] core_pc;
    logic        core_reset, core_clock_en, halted, exit_success;
    logic [31:0] exit_pc, cycle_count;

    int          checks;
    int          failures;
    logic        preload_en;

    always #5 clock = ~clock;

    cpu_run_ctrl #(
        .RESET_CYCLES    (RC),
        .DEBOUNCE_CYCLES (DEB)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .button_rst_n  (button_rst_n),
        .button_step_n (button_step_n),
        .step_mode     (step_mode),
        .core_exit     (core_exit),
        .core_success  (core_success),
        .core_pc       (core_pc),
        .core_reset    (core_reset),
        .core_clock_en (core_clock_en),
        .halted        (halted),
        .exit_success  (exit_success),
        .exit_pc       (exit_pc),
        .cycle_count   (cycle_count)
    );

    // Behavioural model. Buttons: a level is accepted once DEB+1 consecutive synchronized
    // samples agree; the synchronized sample lags the raw pin by two edges.
    int          m_mode, m_hold;
    int          m_run [2];
    bit          m_s1 [2], m_s2 [2], m_last [2], m_lvl [2];
    bit          m_step_prev, m_valid;
    bit          m_cr, m_en, m_halt, m_succ;
    logic [31:0] m_pc, m_cc;

    always @(posedge clock) begin
        bit raw [2];
        bit evt, fsm_rst, cur;
        raw[0]  = button_rst_n;
        raw[1]  = button_step_n;
        evt     = 1'b0;
        fsm_rst = 1'b1;
        if (!reset_n) begin
            for (int i = 0; i < 2; i++) begin
                m_s1[i]   = 1'b1;
                m_s2[i]   = 1'b1;
                m_last[i] = 1'b1;
                m_run[i]  = 1;
                m_lvl[i]  = 1'b1;
            end
            m_step_prev = 1'b1;
            m_valid     = 1'b1;
        end else begin
            evt         = m_step_prev && !m_lvl[1];
            fsm_rst     = !m_lvl[0];
            m_step_prev = m_lvl[1];
            for (int i = 0; i < 2; i++) begin
                cur = m_s2[i];
                if (cur == m_last[i]) m_run[i] = (m_run[i] < 1000) ? m_run[i] + 1 : m_run[i];
                else m_run[i] = 1;
                m_last[i] = cur;
                if (m_run[i] >= DEB + 1) m_lvl[i] = cur;
                m_s2[i] = m_s1[i];
                m_s1[i] = raw[i];
            end
        end
        if (fsm_rst) begin
            m_mode = M_HOLD;
            m_hold = RC - 1;
            m_cr   = 1'b1;
            m_en   = 1'b0;
            m_halt = 1'b0;
            m_succ = 1'b0;
            m_pc   = '0;
            m_cc   = '0;
        end else begin
            if (preload_en) m_cc = 32'hFFFF_FFFE;
            if (m_en && !m_cr && m_cc != 32'hFFFF_FFFF) m_cc = m_cc + 32'd1;
            if ((m_mode == M_RUN || m_mode == M_PULSE) && core_exit) begin
                m_succ = core_success;
                m_pc   = core_pc;
            end
            case (m_mode)
                M_HOLD:  if (m_hold == 0) m_mode = step_mode ? M_IDLE : M_RUN;
                         else m_hold = m_hold - 1;
                M_RUN:   if (core_exit) m_mode = M_HALT;
                         else if (step_mode) m_mode = M_IDLE;
                M_IDLE:  if (evt) m_mode = M_PULSE;
                         else if (!step_mode) m_mode = M_RUN;
                M_PULSE: m_mode = core_exit ? M_HALT : M_IDLE;
                default: ;
            endcase
            m_cr   = (m_mode == M_HOLD);
            m_en   = (m_mode == M_HOLD) || (m_mode == M_RUN) || (m_mode == M_PULSE);
            m_halt = (m_mode == M_HALT);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Advance one edge and compare every output against the model.
    task automatic tick();
        @(posedge clock);
        #1;
        if (m_valid) begin
            chk("core_reset", 32'(core_reset), 32'(m_cr));
            chk("core_clock_en", 32'(core_clock_en), 32'(m_en));
            chk("halted", 32'(halted), 32'(m_halt));
            chk("exit_success", 32'(exit_success), 32'(m_succ));
            chk("exit_pc", exit_pc, m_pc);
            chk("cycle_count", cycle_count, m_cc);
        end
    endtask

    initial begin
        int pulses;
        int step_left, rst_left, nrst_left;
        checks        = 0;
        failures      = 0;
        preload_en    = 1'b0;
        reset_n       = 1'b0;
        button_rst_n  = 1'b1;
        button_step_n = 1'b1;
        step_mode     = 1'b0;
        core_exit     = 1'b0;
        core_success  = 1'b0;
        core_pc       = '0;

        // Power-on reset, then the hold window and the first counted cycles.
        tick();
        chk("rst_core_reset", 32'(core_reset), 32'd1);
        chk("rst_clock_en", 32'(core_clock_en), 32'd0);
        chk("rst_cycle_count", cycle_count, 32'd0);
        tick();
        tick();
        reset_n = 1'b1;
        for (int k = 1; k < 100; k++) begin
            tick();
            if (k <= 19) begin
                chk("hold_core_reset", 32'(core_reset), 32'(k < 16));
                chk("hold_clock_en", 32'(core_clock_en), 32'd1);
            end
            if (k == 19) chk("count_start", cycle_count, 32'd3);
        end

        // Exit in free run on the 100th edge after release.
        core_exit    = 1'b1;
        core_success = 1'b1;
        core_pc      = 32'h0000_0044;
        tick();
        core_exit = 1'b0;
        chk("exit_halted", 32'(halted), 32'd1);
        chk("exit_clock_en", 32'(core_clock_en), 32'd0);
        chk("exit_pc_lit", exit_pc, 32'h44);
        chk("exit_success_lit", 32'(exit_success), 32'd1);
        chk("exit_count_lit", cycle_count, 32'd84);
        repeat (5) tick();
        core_exit    = 1'b1;
        core_success = 1'b0;
        core_pc      = 32'h0000_0088;
        tick();
        core_exit = 1'b0;
        tick();
        chk("halt_ignores_exit_pc", exit_pc, 32'h44);
        chk("halt_count_frozen", cycle_count, 32'd84);

        // Reset button held for 10 cycles while halted.
        button_rst_n = 1'b0;
        repeat (10) tick();
        chk("btn_rst_halted", 32'(halted), 32'd0);
        chk("btn_rst_pc", exit_pc, 32'd0);
        chk("btn_rst_count", cycle_count, 32'd0);
        chk("btn_rst_clock_en", 32'(core_clock_en), 32'd0);
        button_rst_n = 1'b1;
        repeat (22) tick();
        chk("btn_rel_still_reset", 32'(core_reset), 32'd1);
        tick();
        chk("btn_rel_reset_done", 32'(core_reset), 32'd0);
        chk("btn_rel_running", 32'(core_clock_en), 32'd1);

        // Saturation of the cycle counter.
        repeat (3) tick();
        #2;
        force dut.cycle_count_q = 32'hFFFF_FFFE;
        preload_en = 1'b1;
        #1;
        release dut.cycle_count_q;
        tick();
        preload_en = 1'b0;
        tick();
        tick();
        chk("count_saturated", cycle_count, 32'hFFFF_FFFF);

        // Single-step mode: three presses, then a short glitch.
        step_mode = 1'b1;
        reset_n   = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        repeat (20) tick();
        chk("step_idle_clock_en", 32'(core_clock_en), 32'd0);
        chk("step_idle_count", cycle_count, 32'd0);
        pulses = 0;
        for (int p = 0; p < 3; p++) begin
            button_step_n = 1'b0;
            for (int k = 0; k < 12; k++) begin
                tick();
                if (core_clock_en) pulses++;
            end
            button_step_n = 1'b1;
            for (int k = 0; k < 12; k++) begin
                tick();
                if (core_clock_en) pulses++;
            end
        end
        chk("step_pulses", 32'(pulses), 32'd3);
        chk("step_count", cycle_count, 32'd3);
        button_step_n = 1'b0;
        tick();
        tick();
        button_step_n = 1'b1;
        repeat (12) tick();
        chk("glitch_count", cycle_count, 32'd3);

        // Step press on the same edge that step_mode drops.
        button_step_n = 1'b0;
        repeat (7) tick();
        step_mode = 1'b0;
        tick();
        chk("drop_pulse", 32'(core_clock_en), 32'd1);
        tick();
        chk("drop_idle", 32'(core_clock_en), 32'd0);
        tick();
        chk("drop_run", 32'(core_clock_en), 32'd1);
        button_step_n = 1'b1;
        repeat (10) tick();

        // Random phase.
        step_left = 0;
        rst_left  = 0;
        nrst_left = 0;
        for (int c = 0; c < 4000; c++) begin
            if (step_left == 0) begin
                button_step_n = ~button_step_n;
                step_left     = int'($urandom_range(1, 14));
            end
            step_left--;
            if (rst_left > 0) begin
                rst_left--;
                if (rst_left == 0) button_rst_n = 1'b1;
            end else if ($urandom_range(0, 149) == 0) begin
                button_rst_n = 1'b0;
                rst_left     = int'($urandom_range(1, 15));
            end
            if (nrst_left > 0) begin
                nrst_left--;
                if (nrst_left == 0) reset_n = 1'b1;
            end else if ($urandom_range(0, 499) == 0) begin
                reset_n   = 1'b0;
                nrst_left = int'($urandom_range(1, 3));
            end
            if ($urandom_range(0, 39) == 0) step_mode = ~step_mode;
            core_exit    = ($urandom_range(0, 29) == 0);
            core_success = 1'($urandom_range(0, 1));
            core_pc      = $urandom;
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
